field_extractor: RTL

Programmable packet field extractor for the OpenFlow switch datapath. It loads a compiled field program over a word-serial config port into up to NUM_FIELDS reserved registers, each holding a start/end bit position. It then slices each accepted packet into right-aligned field values, one field per cycle, and presents them on a valid/ready output. It succeeds the fixed-width `selector` and feeds the match stage.

---
 rtl/field_extractor.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/field_extractor.sv
// Programmable field extractor: word-serial program load, then slices each packet into right-aligned fields, one per cycle.
// Latency: accept at edge T -> out_valid after T+N+1 (T+1 for N=0). Backpressure: held out_valid stalls pkt_ready and the final config word.
module field_extractor #(
    parameter int PACKET_SIZE = 40,
    parameter int NUM_FIELDS  = 4,
    parameter int POS_W       = 11,
    parameter int FIELD_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [POS_W-1:0]              cfg_data,
    output logic                          cfg_err,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    input  logic [PACKET_SIZE-1:0]        pkt_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_fields,
    output logic [NUM_FIELDS-1:0]         out_mask
);

    localparam int CNT_W = 5;
    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    typedef enum logic [1:0] {CFG_STATUS, CFG_COUNT, CFG_START, CFG_END} cfg_st_e;
    typedef enum logic [1:0] {IDLE, EXTRACT, OUTPUT} pkt_st_e;

    cfg_st_e                cfg_st_q;
    logic                   cfg_err_q;
    logic [IDX_W-1:0]       cfg_idx_q;
    logic [CNT_W-1:0]       shd_n_q;
    logic [POS_W-1:0]       start_q;
    logic [POS_W-1:0]       shd_start_q [NUM_FIELDS];
    logic [POS_W-1:0]       shd_end_q   [NUM_FIELDS];
    logic [CNT_W-1:0]       act_n_q;
    logic [POS_W-1:0]       act_start_q [NUM_FIELDS];
    logic [POS_W-1:0]       act_end_q   [NUM_FIELDS];

    pkt_st_e                pkt_st_q;
    logic [PACKET_SIZE-1:0] pkt_q;
    logic [CNT_W-1:0]       run_n_q;
    logic [IDX_W-1:0]       pkt_idx_q;
    logic [FIELD_W-1:0]     fld_q [NUM_FIELDS];
    logic [NUM_FIELDS-1:0]  mask_q;
    logic                   out_vld_q;

    logic                   cfg_last_d;
    logic                   cfg_hs_d;
    logic                   pair_ok_d;
    logic                   commit_d;
    logic [CNT_W-1:0]       cnt_d;
    logic                   cnt_ok_d;
    logic                   pkt_hs_d;
    logic [NUM_FIELDS-1:0]  act_mask_d;
    logic [POS_W-1:0]       cur_s_d;
    logic [POS_W-1:0]       cur_e_d;
    logic [POS_W:0]         wid_d;
    logic [PACKET_SIZE-1:0] shifted_d;
    logic [PACKET_SIZE-1:0] lowmask_d;
    logic [FIELD_W-1:0]     field_d;

    // The last end word may only be taken while no packet is in flight, so a commit never races an extraction.
    assign cfg_last_d = (cfg_st_q == CFG_END) && (CNT_W'(cfg_idx_q) == shd_n_q - CNT_W'(1));
    assign cfg_ready  = !(cfg_last_d && (pkt_st_q != IDLE));
    assign cfg_hs_d   = cfg_valid && cfg_ready;
    assign pair_ok_d  = (start_q <= cfg_data) && (32'(cfg_data) < PACKET_SIZE);
    assign commit_d   = cfg_hs_d && cfg_last_d && pair_ok_d;
    assign cnt_d      = cfg_data[CNT_W-1:0];
    assign cnt_ok_d   = (cnt_d != '0) && (32'(cnt_d) <= NUM_FIELDS);

    assign pkt_ready  = (pkt_st_q == IDLE) && !commit_d;
    assign pkt_hs_d   = pkt_valid && pkt_ready;

    always_comb begin
        act_mask_d = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            act_mask_d[i] = (CNT_W'(i) < act_n_q);
        end
    end

    // Field width can reach PACKET_SIZE, where the shifted-in mask is all zeros and the low mask all ones.
    assign cur_s_d   = act_start_q[pkt_idx_q];
    assign cur_e_d   = act_end_q[pkt_idx_q];
    assign wid_d     = {1'b0, cur_e_d} - {1'b0, cur_s_d} + (POS_W+1)'(1);
    assign shifted_d = pkt_q >> cur_s_d;
    assign lowmask_d = ~({PACKET_SIZE{1'b1}} << wid_d);
    assign field_d   = FIELD_W'(shifted_d & lowmask_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_st_q  <= CFG_STATUS;
            cfg_err_q <= 1'b0;
            cfg_idx_q <= '0;
            shd_n_q   <= '0;
            start_q   <= '0;
            act_n_q   <= '0;
            for (int k = 0; k < NUM_FIELDS; k++) begin
                shd_start_q[k] <= '0;
                shd_end_q[k]   <= '0;
                act_start_q[k] <= '0;
                act_end_q[k]   <= '0;
            end
        end else if (cfg_hs_d) begin
            case (cfg_st_q)
                CFG_STATUS: begin
                    if (cfg_data[4:0] == 5'b00001) begin
                        cfg_err_q <= 1'b0;
                        cfg_st_q  <= CFG_COUNT;
                    end else begin
                        cfg_err_q <= 1'b1;
                    end
                end
                CFG_COUNT: begin
                    if (cnt_ok_d) begin
                        shd_n_q   <= cnt_d;
                        cfg_idx_q <= '0;
                        cfg_st_q  <= CFG_START;
                    end else begin
                        cfg_err_q <= 1'b1;
                        cfg_st_q  <= CFG_STATUS;
                    end
                end
                CFG_START: begin
                    start_q  <= cfg_data;
                    cfg_st_q <= CFG_END;
                end
                CFG_END: begin
                    if (!pair_ok_d) begin
                        cfg_err_q <= 1'b1;
                        cfg_st_q  <= CFG_STATUS;
                    end else begin
                        shd_start_q[cfg_idx_q] <= start_q;
                        shd_end_q[cfg_idx_q]   <= cfg_data;
                        if (cfg_last_d) begin
                            act_n_q <= shd_n_q;
                            for (int k = 0; k < NUM_FIELDS; k++) begin
                                if (IDX_W'(k) == cfg_idx_q) begin
                                    act_start_q[k] <= start_q;
                                    act_end_q[k]   <= cfg_data;
                                end else begin
                                    act_start_q[k] <= shd_start_q[k];
                                    act_end_q[k]   <= shd_end_q[k];
                                end
                            end
                            cfg_st_q <= CFG_STATUS;
                        end else begin
                            cfg_idx_q <= cfg_idx_q + IDX_W'(1);
                            cfg_st_q  <= CFG_START;
                        end
                    end
                end
                default: cfg_st_q <= CFG_STATUS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_st_q  <= IDLE;
            pkt_q     <= '0;
            run_n_q   <= '0;
            pkt_idx_q <= '0;
            mask_q    <= '0;
            out_vld_q <= 1'b0;
            for (int k = 0; k < NUM_FIELDS; k++) begin
                fld_q[k] <= '0;
            end
        end else begin
            case (pkt_st_q)
                IDLE: begin
                    if (pkt_hs_d) begin
                        pkt_q     <= pkt_data;
                        run_n_q   <= act_n_q;
                        pkt_idx_q <= '0;
                        mask_q    <= act_mask_d;
                        for (int k = 0; k < NUM_FIELDS; k++) begin
                            fld_q[k] <= '0;
                        end
                        pkt_st_q  <= (act_n_q == '0) ? OUTPUT : EXTRACT;
                    end
                end
                EXTRACT: begin
                    fld_q[pkt_idx_q] <= field_d;
                    if (CNT_W'(pkt_idx_q) == run_n_q - CNT_W'(1)) begin
                        pkt_st_q <= OUTPUT;
                    end else begin
                        pkt_idx_q <= pkt_idx_q + IDX_W'(1);
                    end
                end
                // out_valid rises one cycle after entering OUTPUT, then holds until taken.
                OUTPUT: begin
                    if (!out_vld_q) begin
                        out_vld_q <= 1'b1;
                    end else if (out_ready) begin
                        out_vld_q <= 1'b0;
                        pkt_st_q  <= IDLE;
                    end
                end
                default: pkt_st_q <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_pack
            assign out_fields[gi*FIELD_W +: FIELD_W] = fld_q[gi];
        end
    endgenerate

    assign out_mask  = mask_q;
    assign out_valid = out_vld_q;
    assign cfg_err   = cfg_err_q;

endmodule
